steer_pi: RTL and testbench



---
 rtl/steer_pi_if.sv | 13 +
 rtl/steer_pi.sv | 157 +++++++++++++++
 tb/tb_steer_pi.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/steer_pi_if.sv
// Steering PI bundle: drive enable, error sample strobe and the motor command outputs.
interface steer_pi_if;
  logic               go;
  logic               err_vld;
  logic signed [11:0] error;
  logic signed [10:0] lft;
  logic signed [10:0] rht;
  logic               mtr_vld;
  logic               busy;

  modport master (output go, err_vld, error, input lft, rht, mtr_vld, busy);
  modport slave  (input go, err_vld, error, output lft, rht, mtr_vld, busy);
endinterface

// File: rtl/steer_pi.sv
// Steering PI controller: turns a signed steering error into differential
// left/right motor commands around a forward base speed, one sample at a time.
module steer_pi #(
  parameter int P_COEFF = 3,
  parameter int I_SHIFT = 4,
  parameter int BASE    = 400
) (
  input logic       clk,
  input logic       rst,
  steer_pi_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CALC_P, CALC_I, SUM, OUT} state_t;

  localparam logic signed [13:0] P_EXT    = 14'(P_COEFF);
  localparam logic signed [10:0] BASE_11  = 11'(BASE);
  localparam logic signed [15:0] BASE_EXT = {{5{BASE_11[10]}}, BASE_11};

  state_t state;
  state_t state_nxt;

  logic signed [9:0]  err_sat;
  logic signed [13:0] p_term;
  logic signed [14:0] integ;
  logic signed [10:0] pid;
  logic signed [10:0] lft_q;
  logic signed [10:0] rht_q;
  logic               mtr_vld_q;

  logic signed [9:0]  err_clip;
  logic signed [13:0] err_sat_ext;
  logic signed [13:0] p_prod;
  logic signed [15:0] integ_sum;
  logic signed [14:0] integ_clamp;
  logic signed [14:0] integ_shr;
  logic signed [16:0] pid_sum;
  logic signed [10:0] pid_clamp;
  logic signed [15:0] lft_sum;
  logic signed [15:0] rht_sum;
  logic signed [10:0] lft_clamp;
  logic signed [10:0] rht_clamp;

  logic ld_err;
  logic en_p;
  logic en_i;
  logic en_sum;
  logic en_out;
  logic busy;

  // State register; reset parks the FSM in IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a fixed walk through the pipeline stages, any go drop aborts to IDLE.
  always_comb begin
    state_nxt = state;
    if (!bus.go) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.err_vld) state_nxt = CALC_P;
        CALC_P:  state_nxt = CALC_I;
        CALC_I:  state_nxt = SUM;
        SUM:     state_nxt = OUT;
        OUT:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-state stage enables and the busy flag, decoded from the current state.
  always_comb begin
    ld_err = 1'b0;
    en_p   = 1'b0;
    en_i   = 1'b0;
    en_sum = 1'b0;
    en_out = 1'b0;
    busy   = 1'b1;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        ld_err = bus.go && bus.err_vld;
      end
      CALC_P:  en_p   = 1'b1;
      CALC_I:  en_i   = 1'b1;
      SUM:     en_sum = 1'b1;
      OUT:     en_out = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

  // Saturating arithmetic; every sum is widened to 16+ bits so nothing wraps before clamping.
  always_comb begin
    if (bus.error > 12'sd511)       err_clip = 10'sd511;
    else if (bus.error < -12'sd512) err_clip = -10'sd512;
    else                            err_clip = bus.error[9:0];

    err_sat_ext = {{4{err_sat[9]}}, err_sat};
    p_prod      = err_sat_ext * P_EXT;

    integ_sum = {integ[14], integ} + {{6{err_sat[9]}}, err_sat};
    if (integ_sum > 16'sd16383)       integ_clamp = 15'sd16383;
    else if (integ_sum < -16'sd16383) integ_clamp = -15'sd16383;
    else                              integ_clamp = integ_sum[14:0];

    integ_shr = integ >>> I_SHIFT;
    pid_sum   = {{3{p_term[13]}}, p_term} + {{2{integ_shr[14]}}, integ_shr};
    if (pid_sum > 17'sd1023)       pid_clamp = 11'sd1023;
    else if (pid_sum < -17'sd1023) pid_clamp = -11'sd1023;
    else                           pid_clamp = pid_sum[10:0];

    lft_sum = BASE_EXT + {{5{pid[10]}}, pid};
    rht_sum = BASE_EXT - {{5{pid[10]}}, pid};
    if (lft_sum > 16'sd1023)       lft_clamp = 11'sd1023;
    else if (lft_sum < -16'sd1023) lft_clamp = -11'sd1023;
    else                           lft_clamp = lft_sum[10:0];
    if (rht_sum > 16'sd1023)       rht_clamp = 11'sd1023;
    else if (rht_sum < -16'sd1023) rht_clamp = -11'sd1023;
    else                           rht_clamp = rht_sum[10:0];
  end

  // Datapath registers: reset clears everything, go low brakes the motors and empties the integrator.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sat   <= '0;
      p_term    <= '0;
      integ     <= '0;
      pid       <= '0;
      lft_q     <= '0;
      rht_q     <= '0;
      mtr_vld_q <= 1'b0;
    end else if (!bus.go) begin
      integ     <= '0;
      lft_q     <= '0;
      rht_q     <= '0;
      mtr_vld_q <= 1'b0;
    end else begin
      mtr_vld_q <= en_out;
      if (ld_err) err_sat <= err_clip;
      if (en_p)   p_term  <= p_prod;
      if (en_i)   integ   <= integ_clamp;
      if (en_sum) pid     <= pid_clamp;
      if (en_out) begin
        lft_q <= lft_clamp;
        rht_q <= rht_clamp;
      end
    end
  end

  assign bus.lft     = lft_q;
  assign bus.rht     = rht_q;
  assign bus.mtr_vld = mtr_vld_q;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_steer_pi.sv
// Bench for steer_pi: randomized and directed samples, expected motor commands
// queued at acceptance and matched by an independent monitor on each mtr_vld pulse.
module tb_steer_pi;
  localparam int P_COEFF = 3;
  localparam int I_SHIFT = 4;
  localparam int BASE    = 400;

  typedef struct {
    int lft;
    int rht;
    int edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  steer_pi_if bus ();

  steer_pi #(.P_COEFF(P_COEFF), .I_SHIFT(I_SHIFT), .BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   errors   = 0;
  int   checks   = 0;
  int   edge_cnt = 0;
  exp_t sb_q[$];

  int integ_m   = 0;
  bit pend      = 1'b0;
  int pend_edge = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Count rising edges so expected mtr_vld timing can be stated in edges.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got=%0d expected=%0d", name, edge_cnt, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model, then check per-cycle outputs.
  task automatic applyStimulus(input bit r, input bit g, input bit v, input int e);
    int   n;
    bit   abort_chk;
    int   es;
    int   p;
    int   pid;
    exp_t x;
    @(negedge clk);
    rst         = r;
    bus.go      = g;
    bus.err_vld = v;
    bus.error   = 12'(e);
    n           = edge_cnt + 1;
    abort_chk   = 1'b0;
    if (pend && n >= pend_edge + 5) pend = 1'b0;
    if (r) begin
      if (pend) sb_q.delete(sb_q.size() - 1);
      pend    = 1'b0;
      integ_m = 0;
    end else if (!g) begin
      if (pend) sb_q.delete(sb_q.size() - 1);
      pend      = 1'b0;
      integ_m   = 0;
      abort_chk = 1'b1;
    end else if (v && !pend) begin
      es        = clampi(e, -512, 511);
      p         = P_COEFF * es;
      integ_m   = clampi(integ_m + es, -16383, 16383);
      pid       = clampi(p + (integ_m >>> I_SHIFT), -1023, 1023);
      x.lft     = clampi(BASE + pid, -1023, 1023);
      x.rht     = clampi(BASE - pid, -1023, 1023);
      x.edge_no = n + 4;
      sb_q.push_back(x);
      pend      = 1'b1;
      pend_edge = n;
    end
    @(posedge clk);
    #1;
    checkOutput("busy", int'(bus.busy), (!r && pend && n < pend_edge + 4) ? 1 : 0);
    if (r || abort_chk) begin
      checkOutput(r ? "rst_lft" : "brake_lft", int'(bus.lft), 0);
      checkOutput(r ? "rst_rht" : "brake_rht", int'(bus.rht), 0);
      checkOutput(r ? "rst_mtr_vld" : "brake_mtr_vld", int'(bus.mtr_vld), 0);
    end
  endtask

  // Monitor: every mtr_vld pulse must match the oldest queued expectation in value and timing.
  always @(negedge clk) begin
    exp_t x;
    if (bus.mtr_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_mtr_vld at edge %0d: got pulse, expected none", edge_cnt);
      end else begin
        x = sb_q.pop_front();
        checkOutput("mtr_vld_edge", edge_cnt, x.edge_no);
        checkOutput("lft", int'(bus.lft), x.lft);
        checkOutput("rht", int'(bus.rht), x.rht);
      end
    end
  end

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
  endtask

  // Main sequence: directed corner cases followed by a randomized soak.
  initial begin
    int e;
    bit r;
    bit g;
    bit v;
    rst         = 1'b1;
    bus.go      = 1'b0;
    bus.err_vld = 1'b0;
    bus.error   = '0;

    doReset();

    applyStimulus(1'b0, 1'b1, 1'b1, 0);
    idle(5);

    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 100);
    idle(5);

    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 2047);
    idle(5);
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, -2048);
    idle(5);

    doReset();
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b1, 1'b1, 511);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 1'b1, -512);
    idle(5);

    applyStimulus(1'b0, 1'b1, 1'b1, 50);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, -300);
    idle(6);

    applyStimulus(1'b0, 1'b1, 1'b1, 200);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 100);
    idle(5);

    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) == 0);
      g = ($urandom_range(0, 15) != 0);
      v = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       e = int'($urandom_range(0, 4095)) - 2048;
        1:       e = int'($urandom_range(0, 1200)) - 600;
        2:       e = ($urandom_range(0, 1) == 0) ? 2047 : -2048;
        default: e = int'($urandom_range(0, 200)) - 100;
      endcase
      applyStimulus(r, g, v, e);
    end

    idle(10);
    checkOutput("pending_at_end", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
